// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and
// counter-width helpers used by the TX controller and its bit timer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TICK_CNT_W = cnt_width(OVERSAMPLE_DEFAULT);
  localparam int BIT_CNT_W  = cnt_width(DATA_BITS_DEFAULT);

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte hand-off between a requester (TX FIFO or user logic) and the UART
// transmit controller: data qualified by a valid/ready handshake.
interface uart_tx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: flags the tick that closes one bit period.
// Holding clear keeps the count at zero and suppresses bit_end.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic system_clk,
  input  logic rst,
  input  logic clear,
  input  logic tick_in,
  output logic bit_end
);

  localparam int              CNT_W     = cnt_width(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] tick_cnt_reg;
  logic [CNT_W-1:0] tick_cnt_next;

  always_comb begin
    tick_cnt_next = tick_cnt_reg;
    if (clear) begin
      tick_cnt_next = '0;
    end else if (tick_in) begin
      tick_cnt_next = (tick_cnt_reg == LAST_TICK) ? '0 : tick_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
    end
  end

  assign bit_end = tick_in && !clear && (tick_cnt_reg == LAST_TICK);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start / data LSB-first / [parity] / stop bits,
// each OVERSAMPLE ticks long. Parity bit is compiled in with UART_TX_PARITY_EN.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic          system_clk,
  input  logic          rst,
  input  logic          tick_in,
  uart_tx_ctrl_if.slave req,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  localparam int               BIT_W     = cnt_width(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam bit PARAMS_OK = (DATA_BITS >= 5) && (DATA_BITS <= 9) && (OVERSAMPLE >= 2) &&
                             (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
                             (PARITY_ODD >= 0) && (PARITY_ODD <= 1);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("uart_tx_ctrl: unsupported parameter combination");
    end
  endgenerate

  uart_state_e          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  localparam logic      PARITY_SENSE = (PARITY_ODD != 0);
  logic [DATA_BITS-1:0] latched_reg, latched_next;
`endif

  // The timer is held cleared while idle, so a tick on the accept cycle is lost.
  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .system_clk (system_clk),
    .rst        (rst),
    .clear      (state_reg == IDLE),
    .tick_in    (tick_in),
    .bit_end    (bit_end)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    tx_next      = tx_reg;
    done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
    latched_next = latched_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (req.tx_valid) begin
          shift_next   = req.tx_data;
`ifdef UART_TX_PARITY_EN
          latched_next = req.tx_data;
`endif
          bit_cnt_next = '0;
          state_next   = START;
          tx_next      = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LAST_DATA) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
            tx_next      = (^latched_reg) ^ PARITY_SENSE;
`else
            state_next   = STOP;
            tx_next      = 1'b1;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            tx_next      = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (bit_cnt_reg == LAST_STOP) begin
            state_next   = IDLE;
            done_next    = 1'b1;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= 1'b1;
      done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      latched_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
      latched_reg <= latched_next;
`endif
    end
  end

  assign req.tx_ready = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign tx           = tx_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (1 and 2 stop bits, even/odd parity sense)
// checked every cycle against a tick-counting frame model plus literal frame pins.
module tb_uart_tx_ctrl;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
  localparam int LEN_D0 = 176, LEN_D1 = 192, LOW_00 = 640;
  localparam logic [15:0] PAT_A5_D0 = 16'h054A, PAT_3C_D0 = 16'h0478;
  localparam logic [15:0] PAT_A5_D1 = 16'h0F4A, PAT_81_D1 = 16'h0F02;
`else
  localparam int PAR = 0;
  localparam int LEN_D0 = 160, LEN_D1 = 176, LOW_00 = 576;
  localparam logic [15:0] PAT_A5_D0 = 16'h034A, PAT_3C_D0 = 16'h0278;
  localparam logic [15:0] PAT_A5_D1 = 16'h074A, PAT_81_D1 = 16'h0702;
`endif

  logic system_clk = 1'b0;
  logic rst        = 1'b1;
  logic tick_in    = 1'b0;
  logic tx0, tx1, busy0, busy1, done0, done1;
  int   checks = 0;
  int   errors = 0;
  int   tick_div = 1;
  int   tick_cyc = 0;

  uart_tx_ctrl_if #(.DATA_BITS(DB)) if0 ();
  uart_tx_ctrl_if #(.DATA_BITS(DB)) if1 ();

  uart_tx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .system_clk (system_clk), .rst (rst), .tick_in (tick_in), .req (if0.slave),
    .tx (tx0), .busy (busy0), .done (done0));

  uart_tx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .system_clk (system_clk), .rst (rst), .tick_in (tick_in), .req (if1.slave),
    .tx (tx1), .busy (busy1), .done (done1));

  always #5 system_clk = ~system_clk;

  // Tick source: one pulse every tick_div cycles, changed on the falling edge.
  always @(negedge system_clk) begin
    tick_cyc++;
    tick_in = ((tick_cyc % tick_div) == 0);
  end

  function automatic int stop_bits(input int d);
    return (d == 0) ? 1 : 2;
  endfunction
  function automatic logic parity_odd(input int d);
    return (d != 0);
  endfunction
  function automatic logic get_tx(input int d);
    return (d == 0) ? tx0 : tx1;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_done(input int d);
    return (d == 0) ? done0 : done1;
  endfunction
  function automatic logic get_ready(input int d);
    return (d == 0) ? if0.tx_ready : if1.tx_ready;
  endfunction
  function automatic logic get_valid(input int d);
    return (d == 0) ? if0.tx_valid : if1.tx_valid;
  endfunction
  function automatic logic [7:0] get_data(input int d);
    return (d == 0) ? if0.tx_data : if1.tx_data;
  endfunction

  task automatic set_req(input int d, input logic v, input logic [7:0] data);
    if (d == 0) begin
      if0.tx_valid = v;
      if0.tx_data  = data;
    end else begin
      if1.tx_valid = v;
      if1.tx_data  = data;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame as a bit list: bit k of the result is the line level during bit period k.
  function automatic logic [15:0] frame_of(input int d, input logic [7:0] data);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1 + i] = data[i];
    if (PAR != 0) f[1 + DB] = (^data) ^ parity_odd(d);
    return f;
  endfunction

  // Model: a frame in flight is just a bit list and a count of ticks seen since accept.
  logic        m_active [2];
  logic        m_done   [2];
  int          m_ticks  [2];
  int          m_nbits  [2];
  logic [15:0] m_bits   [2];

  always @(posedge system_clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_active[d] = 1'b0;
        m_done[d]   = 1'b0;
        m_ticks[d]  = 0;
      end else begin
        m_done[d] = 1'b0;
        if (m_active[d]) begin
          if (tick_in) m_ticks[d]++;
          if (m_ticks[d] == m_nbits[d] * OS) begin
            m_active[d] = 1'b0;
            m_done[d]   = 1'b1;
          end
        end else if (get_valid(d)) begin
          m_bits[d]   = frame_of(d, get_data(d));
          m_nbits[d]  = 1 + DB + PAR + stop_bits(d);
          m_ticks[d]  = 0;
          m_active[d] = 1'b1;
        end
      end
    end
  end

  always @(negedge system_clk) begin : compare
    logic exp_tx;
    for (int d = 0; d < 2; d++) begin
      exp_tx = m_active[d] ? m_bits[d][m_ticks[d] / OS] : 1'b1;
      check($sformatf("d%0d_tx", d),    32'(get_tx(d)),    32'(exp_tx));
      check($sformatf("d%0d_busy", d),  32'(get_busy(d)),  32'(m_active[d]));
      check($sformatf("d%0d_ready", d), 32'(get_ready(d)), 32'(!m_active[d]));
      check($sformatf("d%0d_done", d),  32'(get_done(d)),  32'(m_done[d]));
    end
  end

  task automatic wait_done(input int d, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge system_clk);
      if (get_done(d)) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Send one byte with ticks every cycle; return cycles from first tx=0 to done and
  // the line level sampled mid-way through each bit. Pokes tx_data/tx_valid mid-frame.
  task automatic send_capture(input int d, input logic [7:0] data,
                              output int ncyc, output logic [15:0] pat);
    logic seen;
    ncyc = 0;
    pat  = '0;
    seen = 1'b0;
    set_req(d, 1'b1, data);
    for (int i = 0; i < 50; i++) begin
      @(negedge system_clk);
      if (!get_ready(d)) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("d%0d_accept_%0h", d, data), 32'(seen), 32'd1);
    set_req(d, 1'b0, ~data);
    for (int n = 1; n < 4000; n++) begin
      @(negedge system_clk);
      if ((n % OS) == 8 && (n / OS) < 16) pat[n / OS] = get_tx(d);
      if (n == 40) set_req(d, 1'b1, 8'h5A);
      if (n == 41) set_req(d, 1'b0, 8'hC3);
      if (get_done(d)) begin
        ncyc = n;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 2 ms");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int          ncyc;
    int          low_cnt;
    logic [15:0] pat;
    logic        reached;

    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_done[d]   = 1'b0;
      m_ticks[d]  = 0;
      m_nbits[d]  = 0;
      m_bits[d]   = '1;
    end
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    repeat (3) @(negedge system_clk);
    check("rst_tx0",    32'(tx0),         32'd1);
    check("rst_ready0", 32'(if0.tx_ready), 32'd1);
    check("rst_busy0",  32'(busy0),       32'd0);
    check("rst_done0",  32'(done0),       32'd0);
    rst = 1'b0;
    repeat (2) @(negedge system_clk);

    // 0xA5, tick every cycle
    send_capture(0, 8'hA5, ncyc, pat);
    check("a5_len",       32'(ncyc),         32'(LEN_D0));
    check("a5_bits",      32'(pat),          32'(PAT_A5_D0));
    check("a5_ready_done", 32'(if0.tx_ready), 32'd1);
    repeat (3) @(negedge system_clk);

    // 0x00, tick every 4th cycle, accept edge aligned to a tick
    tick_div = 4;
    repeat (8) @(negedge system_clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge system_clk);
      #1;
      if (tick_in) break;
    end
    set_req(0, 1'b1, 8'h00);
    @(negedge system_clk);
    set_req(0, 1'b0, 8'h00);
    low_cnt = 0;
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!tx0) low_cnt++;
      if (done0) begin
        reached = 1'b1;
        break;
      end
      @(negedge system_clk);
    end
    check("slow_done",    32'(reached), 32'd1);
    check("slow_low_len", 32'(low_cnt), 32'(LOW_00));
    tick_div = 1;
    repeat (4) @(negedge system_clk);

    // back-to-back 0x55 then 0xAA with tx_valid held
    set_req(0, 1'b1, 8'h55);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge system_clk);
      if (!if0.tx_ready) begin
        reached = 1'b1;
        break;
      end
    end
    check("b2b_accept1", 32'(reached), 32'd1);
    set_req(0, 1'b1, 8'hAA);
    wait_done(0, "b2b_done1");
    check("b2b_tx_at_done", 32'(tx0), 32'd1);
    @(negedge system_clk);
    check("b2b_start_tx",   32'(tx0),   32'd0);
    check("b2b_start_busy", 32'(busy0), 32'd1);
    set_req(0, 1'b0, 8'h00);
    wait_done(0, "b2b_done2");
    repeat (3) @(negedge system_clk);

    // async reset during the 4th data bit of 0xFF, then a clean 0x3C frame
    set_req(0, 1'b1, 8'hFF);
    @(negedge system_clk);
    set_req(0, 1'b0, 8'h00);
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge system_clk);
      if (m_active[0] && (m_ticks[0] / OS) == 4) begin
        reached = 1'b1;
        break;
      end
    end
    check("ff_reach_bit4", 32'(reached), 32'd1);
    check("ff_busy_bit4",  32'(busy0),   32'd1);
    @(posedge system_clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx",    32'(tx0),         32'd1);
    check("arst_busy",  32'(busy0),       32'd0);
    check("arst_ready", 32'(if0.tx_ready), 32'd1);
    repeat (2) @(negedge system_clk);
    rst = 1'b0;
    @(negedge system_clk);
    send_capture(0, 8'h3C, ncyc, pat);
    check("3c_len",  32'(ncyc), 32'(LEN_D0));
    check("3c_bits", 32'(pat),  32'(PAT_3C_D0));
    repeat (3) @(negedge system_clk);

    // second instance: two stop bits, odd parity sense
    send_capture(1, 8'hA5, ncyc, pat);
    check("d1_a5_len",  32'(ncyc), 32'(LEN_D1));
    check("d1_a5_bits", 32'(pat),  32'(PAT_A5_D1));
    repeat (3) @(negedge system_clk);
    send_capture(1, 8'h81, ncyc, pat);
    check("d1_81_len",  32'(ncyc), 32'(LEN_D1));
    check("d1_81_bits", 32'(pat),  32'(PAT_81_D1));
    repeat (5) @(negedge system_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame-sequencing controller for the UART transmit path.
- Consumes the 16x-oversampled tick from the baud rate generator and accepts bytes over a valid/ready handshake.
- Serialises each byte as start / data (LSB first) / optional parity / stop bits, each bit lasting exactly OVERSAMPLE ticks.
- Sits between the TX FIFO or user logic and the tx pin.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, tick_in pulses per bit period; must match the generator's oversampling factor.
- STOP_BITS, 1, number of stop bits (1 or 2).
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- system_clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- tick_in  in  1  single-cycle oversample tick from the baud rate generator.
- tx_data  in  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  in  1  requester has data.
- tx_ready  out  1  controller can accept; transfer occurs when tx_valid && tx_ready at a rising edge.
- tx  out  1  serial line, registered; idle high.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values: tx=1, tx_ready=1, busy=0, done=0, state IDLE, all counters 0. Reset is asynchronous, so assertion mid-frame forces tx=1 immediately and the frame is abandoned.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1, tx_ready=1.
  - On handshake: latch tx_data into a shift register, clear tick_cnt and bit_cnt, go to START.
  - tx=0, busy=1, tx_ready=0 from the next cycle.
  - A tick_in coinciding with the accept cycle is ignored.
- Bit timing:
  - tick_cnt (width $clog2(OVERSAMPLE)) increments only on tick_in.
  - A bit ends on a cycle where tick_in && tick_cnt==OVERSAMPLE-1; tick_cnt wraps to 0.
  - If tick_in is stuck low, the FSM holds its state and tx indefinitely.
- START: after one bit period go to DATA; tx = shift_reg[0].
- DATA:
  - At each bit end, shift right and increment bit_cnt.
  - After DATA_BITS bits, go to PARITY if compiled in, otherwise STOP.
- STOP:
  - tx=1 for STOP_BITS bit periods.
  - On the final bit end: done=1 for one cycle, busy=0, tx_ready=1, state IDLE, all in that same edge.
- Back-to-back: the earliest next accept is the cycle done is high. The new start bit begins the cycle after, so there is no extra idle bit between frames.
- tx_data and tx_valid changes while busy are ignored. A requester holding tx_valid simply waits.
- Frame length: (1 + DATA_BITS + parity + STOP_BITS) * OVERSAMPLE ticks, plus one cycle of accept latency.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA.
  - tx = ^latched_data ^ PARITY_ODD for one bit period.
  - The parity bit is computed from the byte captured at accept, not from the shifted register.
- Undefined: no PARITY state or logic; DATA goes straight to STOP. PARITY_ODD is unused.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding;
  - OVERSAMPLE_DEFAULT=16, DATA_BITS_DEFAULT=8;
  - width helper constants for tick_cnt and bit_cnt.
- One natural sub-module: uart_bit_timer.
  - Tick counter with clear and a bit_end output; reusable by the future RX controller.
- The FSM, shift register and handshake stay in uart_tx_ctrl.

Test Plan:
- tick_in every cycle, OVERSAMPLE=16, send 0xA5:
  - tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 16 cycles;
  - done pulses exactly 160 cycles after the first tx=0 cycle;
  - tx_ready returns high with done.
- tick_in every 4th cycle, send 0x00 → each bit lasts 64 cycles; tx low for 9 bit periods; busy high throughout.
- tx_valid held high with 0x55 then 0xAA queued → second start bit begins one cycle after the first done; no idle gap; both frames bit-exact.
- Assert rst at the 4th data bit of 0xFF → tx=1, busy=0, tx_ready=1 asynchronously. After release, a new 0x3C frame is sent correctly from its start bit.
- With UART_TX_PARITY_EN, send 0xA5:
  - PARITY_ODD=0 gives parity bit 0; PARITY_ODD=1 gives parity bit 1;
  - frame is 11 bit periods (176 ticks).
- STOP_BITS=2, send 0x81 → tx high for 32 ticks after the last data bit before done; tx_data changes mid-frame have no effect.
